// File: rtl/mc_alu.sv
// rtl/mc_alu.sv - handshaked ALU: registered single-cycle ops, iterative MULU/DIVU
module mc_alu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       cmd,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             overflow,
    output logic             zero,
    output logic             div_by_zero
);
    localparam logic [3:0] CMD_AND  = 4'd0;
    localparam logic [3:0] CMD_OR   = 4'd1;
    localparam logic [3:0] CMD_ADD  = 4'd2;
    localparam logic [3:0] CMD_SUB  = 4'd3;
    localparam logic [3:0] CMD_SLT  = 4'd4;
    localparam logic [3:0] CMD_SLTU = 4'd5;
    localparam logic [3:0] CMD_XOR  = 4'd6;
    localparam logic [3:0] CMD_NOR  = 4'd7;
    localparam logic [3:0] CMD_SLL  = 4'd8;
    localparam logic [3:0] CMD_SRL  = 4'd9;
    localparam logic [3:0] CMD_SRA  = 4'd10;
    localparam logic [3:0] CMD_MULU = 4'd11;
    localparam logic [3:0] CMD_DIVU = 4'd12;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] opnd_q;
    logic             is_div_q;
    logic             accept, is_multi;
    logic [CNT_W-2:0] shamt;
    logic [WIDTH:0]   ext;
    logic [WIDTH-1:0] sc_lo, sc_hi;
    logic             sc_ovf, sc_dbz, sc_zero;
    logic [WIDTH:0]   mul_sum, div_rs, div_diff;
    logic [WIDTH-1:0] it_hi, it_lo;

    assign shamt  = b[CNT_W-2:0];
    assign accept = in_valid && in_ready;

    always_comb begin
        sc_lo    = '0;
        sc_hi    = '0;
        sc_ovf   = 1'b0;
        sc_dbz   = 1'b0;
        ext      = '0;
        is_multi = 1'b0;
        case (cmd)
            CMD_AND:  sc_lo = a & b;
            CMD_OR:   sc_lo = a | b;
            CMD_ADD: begin
                ext    = {a[WIDTH-1], a} + {b[WIDTH-1], b};
                sc_lo  = ext[WIDTH-1:0];
                sc_ovf = ext[WIDTH] ^ ext[WIDTH-1];
            end
            CMD_SUB: begin
                ext    = {a[WIDTH-1], a} - {b[WIDTH-1], b};
                sc_lo  = ext[WIDTH-1:0];
                sc_ovf = ext[WIDTH] ^ ext[WIDTH-1];
            end
            CMD_SLT:  sc_lo = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            CMD_SLTU: sc_lo = {{(WIDTH-1){1'b0}}, a < b};
            CMD_XOR:  sc_lo = a ^ b;
            CMD_NOR:  sc_lo = ~(a | b);
            CMD_SLL:  sc_lo = a << shamt;
            CMD_SRL:  sc_lo = a >> shamt;
            CMD_SRA:  sc_lo = $unsigned($signed(a) >>> shamt);
            CMD_MULU: is_multi = 1'b1;
            CMD_DIVU: begin
                // Divide by zero short-circuits the iteration entirely.
                if (b == '0) begin
                    sc_lo  = '1;
                    sc_hi  = a;
                    sc_dbz = 1'b1;
                end else begin
                    is_multi = 1'b1;
                end
            end
            default: ;
        endcase
        sc_zero = (cmd <= CMD_DIVU) && (sc_lo == '0);
    end

    // result_hi/result_lo double as the working registers while BUSY.
    always_comb begin
        mul_sum  = {1'b0, result_hi} + (result_lo[0] ? {1'b0, opnd_q} : '0);
        div_rs   = {result_hi, result_lo[WIDTH-1]};
        div_diff = div_rs - {1'b0, opnd_q};
        if (is_div_q) begin
            if (!div_diff[WIDTH]) begin
                it_hi = div_diff[WIDTH-1:0];
                it_lo = {result_lo[WIDTH-2:0], 1'b1};
            end else begin
                it_hi = div_rs[WIDTH-1:0];
                it_lo = {result_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            it_hi = mul_sum[WIDTH:1];
            it_lo = {mul_sum[0], result_lo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = is_multi ? S_BUSY : S_DONE;
            S_BUSY: if (cnt == CNT_W'(1)) state_nxt = S_DONE;
            S_DONE: begin
                if (accept)         state_nxt = is_multi ? S_BUSY : S_DONE;
                else if (out_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_IDLE: in_ready = 1'b1;
            S_DONE: begin
                in_ready  = out_ready;
                out_valid = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_lo   <= '0;
            result_hi   <= '0;
            overflow    <= 1'b0;
            zero        <= 1'b0;
            div_by_zero <= 1'b0;
            cnt         <= '0;
            opnd_q      <= '0;
            is_div_q    <= 1'b0;
        end else if (accept) begin
            if (is_multi) begin
                result_hi   <= '0;
                result_lo   <= (cmd == CMD_DIVU) ? a : b;
                opnd_q      <= (cmd == CMD_DIVU) ? b : a;
                is_div_q    <= (cmd == CMD_DIVU);
                cnt         <= CNT_W'(WIDTH);
                overflow    <= 1'b0;
                zero        <= 1'b0;
                div_by_zero <= 1'b0;
            end else begin
                result_lo   <= sc_lo;
                result_hi   <= sc_hi;
                overflow    <= sc_ovf;
                zero        <= sc_zero;
                div_by_zero <= sc_dbz;
            end
        end else if (state == S_BUSY) begin
            result_hi <= it_hi;
            result_lo <= it_lo;
            cnt       <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) zero <= (it_lo == '0);
        end
    end
endmodule

// File: tb/tb_mc_alu.sv
// tb/tb_mc_alu.sv - randomized and directed self-checking bench for mc_alu
module tb_mc_alu;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [3:0]  cmd = 4'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        in_ready, out_valid, overflow, zero, div_by_zero;
    logic [31:0] result_lo, result_hi;

    int vectors = 0;
    int miscompares = 0;

    mc_alu #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .cmd(cmd), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result_lo(result_lo), .result_hi(result_hi), .overflow(overflow),
        .zero(zero), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void golden(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                                   output logic [31:0] lo, output logic [31:0] hi,
                                   output bit ovf, output bit zf, output bit dbz, output bit multi);
        logic [63:0] prod;
        lo = '0; hi = '0; ovf = 0; dbz = 0; multi = 0;
        case (c)
            4'd0:  lo = x & y;
            4'd1:  lo = x | y;
            4'd2:  begin lo = x + y; ovf = (x[31] == y[31]) && (lo[31] != x[31]); end
            4'd3:  begin lo = x - y; ovf = (x[31] != y[31]) && (lo[31] != x[31]); end
            4'd4:  lo = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'd5:  lo = (x < y) ? 32'd1 : 32'd0;
            4'd6:  lo = x ^ y;
            4'd7:  lo = ~(x | y);
            4'd8:  lo = x << y[4:0];
            4'd9:  lo = x >> y[4:0];
            4'd10: lo = $signed(x) >>> y[4:0];
            4'd11: begin
                prod = {32'd0, x} * {32'd0, y};
                lo = prod[31:0]; hi = prod[63:32]; multi = 1;
            end
            4'd12: begin
                if (y == 0) begin lo = 32'hFFFF_FFFF; hi = x; dbz = 1; end
                else begin lo = x / y; hi = x % y; multi = 1; end
            end
            default: ;
        endcase
        zf = (c <= 4'd12) && (lo == 0);
    endfunction

    // Reference: idle/busy/holding-result, results come straight from arithmetic.
    bit          m_busy, m_done, m_rdy, m_acc;
    int          m_cnt;
    logic [31:0] m_lo, m_hi, p_lo, p_hi, g_lo, g_hi;
    bit          m_ovf, m_zf, m_dbz, p_ovf, p_zf, p_dbz, g_ovf, g_zf, g_dbz, g_multi;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_done = 0; m_cnt = 0;
        end else begin
            m_rdy = !m_busy && (!m_done || out_ready);
            m_acc = in_valid && m_rdy;
            if (m_done && out_ready) m_done = 0;
            if (m_busy) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_busy = 0; m_done = 1;
                    m_lo = p_lo; m_hi = p_hi; m_ovf = p_ovf; m_zf = p_zf; m_dbz = p_dbz;
                end
            end
            if (m_acc) begin
                golden(cmd, a, b, g_lo, g_hi, g_ovf, g_zf, g_dbz, g_multi);
                if (g_multi) begin
                    p_lo = g_lo; p_hi = g_hi; p_ovf = g_ovf; p_zf = g_zf; p_dbz = g_dbz;
                    m_busy = 1; m_cnt = 32;
                end else begin
                    m_lo = g_lo; m_hi = g_hi; m_ovf = g_ovf; m_zf = g_zf; m_dbz = g_dbz;
                    m_done = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        #2;
        if (rst_n) begin
            chk("in_ready", in_ready, !m_busy && (!m_done || out_ready));
            chk("out_valid", out_valid, m_done);
            if (m_done) begin
                chk("result_lo", result_lo, m_lo);
                chk("result_hi", result_hi, m_hi);
                chk("overflow", overflow, m_ovf);
                chk("zero", zero, m_zf);
                chk("div_by_zero", div_by_zero, m_dbz);
            end
        end
    end

    task automatic run_op(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                          output int lat, output int stalls);
        @(negedge clk);
        cmd = c; a = x; b = y; in_valid = 1; out_ready = 1;
        @(negedge clk);
        in_valid = 0; cmd = 4'($urandom); a = $urandom; b = $urandom;
        lat = 1; stalls = 0;
        while (!out_valid && lat < 100) begin
            if (!in_ready) stalls++;
            @(negedge clk);
            lat++;
        end
    endtask

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 3))
            0: return 32'($urandom_range(0, 15));
            1: return ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int lat, stalls;
        logic [31:0] t_lo, t_hi;
        bit t_ovf, t_zf, t_dbz, t_multi;

        golden(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, t_lo, t_hi, t_ovf, t_zf, t_dbz, t_multi);
        chk("model_mulu_hi", t_hi, 32'hFFFF_FFFE);
        chk("model_mulu_lo", t_lo, 32'h0000_0001);
        golden(4'd12, 32'd100, 32'd7, t_lo, t_hi, t_ovf, t_zf, t_dbz, t_multi);
        chk("model_divu", {t_hi, t_lo}, {32'd2, 32'd14});

        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_result", {result_hi, result_lo}, 64'd0);
        chk("rst_flags", {overflow, zero, div_by_zero}, 3'b000);
        @(negedge clk);
        rst_n = 1;

        run_op(4'd2, 32'h7FFF_FFFF, 32'd1, lat, stalls);
        chk("add_lat", lat, 1);
        chk("add_lo", result_lo, 32'h8000_0000);
        chk("add_flags", {result_hi, overflow, zero}, {32'd0, 1'b1, 1'b0});
        run_op(4'd3, 32'd5, 32'd5, lat, stalls);
        chk("sub_zero", {result_lo, zero, overflow}, {32'd0, 1'b1, 1'b0});
        run_op(4'd4, 32'hFFFF_FFFF, 32'd1, lat, stalls);
        chk("slt", result_lo, 32'd1);
        run_op(4'd5, 32'hFFFF_FFFF, 32'd1, lat, stalls);
        chk("sltu", result_lo, 32'd0);
        run_op(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, stalls);
        chk("mulu_lat", lat, 33);
        chk("mulu_stalls", stalls, 32);
        chk("mulu_res", {result_hi, result_lo}, 64'hFFFF_FFFE_0000_0001);
        run_op(4'd12, 32'd100, 32'd7, lat, stalls);
        chk("divu_lat", lat, 33);
        chk("divu_res", {result_hi, result_lo}, {32'd2, 32'd14});
        run_op(4'd12, 32'd9, 32'd0, lat, stalls);
        chk("div0_lat", lat, 1);
        chk("div0_res", {result_hi, result_lo, div_by_zero}, {32'd9, 32'hFFFF_FFFF, 1'b1});

        @(negedge clk);
        cmd = 4'd10; a = 32'h8000_0000; b = 32'd4; in_valid = 1; out_ready = 0;
        @(negedge clk);
        in_valid = 0;
        repeat (5) begin
            #1;
            chk("bp_hold_lo", result_lo, 32'hF800_0000);
            chk("bp_hold_ready", {out_valid, in_ready}, 2'b10);
            @(negedge clk);
        end
        cmd = 4'd6; a = 32'hF0; b = 32'hFF; in_valid = 1; out_ready = 1;
        #1;
        chk("bp_same_cycle_accept", in_ready, 1);
        @(negedge clk);
        in_valid = 0;
        #1;
        chk("bp_xor", {out_valid, result_lo}, {1'b1, 32'h0F});

        @(negedge clk);
        cmd = 4'd11; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        repeat (9) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_result", {result_hi, result_lo}, 64'd0);
        chk("arst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        #3;
        chk("post_rst", {in_ready, out_valid}, 2'b10);
        repeat (40) @(negedge clk);

        repeat (3000) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            cmd       = 4'($urandom_range(0, 15));
            a         = rand_opnd();
            b         = rand_opnd();
        end
        @(negedge clk);
        in_valid = 0; out_ready = 1;
        repeat (40) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mc_alu.md
Name: mc_alu

Overview:
- Parametrised, handshaked successor to the single-cycle datapath ALU.
- Registered single-cycle logic/arith/shift ops plus iterative unsigned multiply and divide, with a full 2*WIDTH result.
- Sits between the decode/register-read stage and writeback. Multi-cycle ops stall issue via in_ready.

Parameters:
- WIDTH, 32, operand and result_lo/result_hi width (>= 4).
- CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation request valid.
- in_ready  out  1  block can accept a request this cycle.
- cmd  in  4  operation code (see Behaviour).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B; shift amount is b[CNT_W-2:0].
- out_valid  out  1  result registers hold a valid result.
- out_ready  in  1  consumer accepts the result this cycle.
- result_lo  out  WIDTH  primary result, or product low half, or quotient.
- result_hi  out  WIDTH  product high half or remainder; 0 for single-cycle ops.
- overflow  out  1  signed overflow (ADD/SUB only).
- zero  out  1  result_lo == 0.
- div_by_zero  out  1  DIVU with b == 0.

Behaviour:
- Clocking/reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: state IDLE, out_valid 0, result_lo 0, result_hi 0, overflow 0, zero 0, div_by_zero 0, counter 0, in_ready 1.
- Reset asserted mid-operation aborts the operation with no output.
- cmd encoding:
  - 0 AND, 1 OR, 2 ADD, 3 SUB, 4 SLT (signed), 5 SLTU, 6 XOR (true a^b), 7 NOR.
  - 8 SLL, 9 SRL, 10 SRA, 11 MULU, 12 DIVU.
  - 13-15 reserved: result 0, all flags 0, latency 1.
- Accept: the request is accepted when in_valid && in_ready. a, b and cmd are sampled only at acceptance.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - BUSY: in_ready=0, out_valid=0. Iterating, counter counts down from WIDTH.
  - DONE: out_valid=1. in_ready = out_ready, so a new op is accepted in the same cycle the result is consumed.
- Transitions:
  - IDLE or DONE, accepting a single-cycle op -> DONE. Result registered; out_valid high on the next cycle (latency 1).
  - IDLE or DONE, accepting MULU/DIVU -> BUSY.
  - BUSY, counter reaches 0 -> DONE. out_valid first high WIDTH+1 cycles after acceptance.
  - DONE, out_ready && !in_valid -> IDLE.
  - DONE, !out_ready -> stay in DONE. All outputs stable until consumed.
- ADD/SUB: computed at WIDTH+1 bits with sign extension. overflow = ext[WIDTH] ^ ext[WIDTH-1]. Result wraps modulo 2^WIDTH.
- SLT/SLTU: result_lo = {0..., cmp}.
- Shifts: only the low log2(WIDTH) bits of b are used. SRA replicates a[WIDTH-1].
- MULU: shift-add, one bit per cycle, WIDTH iterations. {result_hi, result_lo} = a*b unsigned, exact 2*WIDTH bits.
- DIVU: restoring, one quotient bit per cycle, WIDTH iterations. result_lo = a/b, result_hi = a%b.
- DIVU with b==0: no iteration; goes to DONE with latency 1. result_lo = all ones, result_hi = a, div_by_zero=1.
- Flags: zero is computed from result_lo for every op, including MULU/DIVU.
- Flag lifetime: overflow and div_by_zero are 0 except for their own op. All flags are registered with the result and valid only while out_valid.
- Operand changes on a/b/cmd while BUSY or DONE have no effect.

Test Plan:
- Reset then ADD a=0x7FFFFFFF, b=1 -> next cycle out_valid=1, result_lo=0x80000000, overflow=1, zero=0, result_hi=0.
- SUB a=5, b=5 -> result_lo=0, zero=1, overflow=0. SLT a=0xFFFFFFFF, b=1 -> 1; SLTU with same operands -> 0.
- MULU a=0xFFFFFFFF, b=0xFFFFFFFF -> in_ready=0 for 32 cycles; out_valid at cycle 33; result_hi=0xFFFFFFFE, result_lo=0x00000001.
- DIVU a=100, b=7 -> after 33 cycles result_lo=14, result_hi=2. DIVU a=9, b=0 -> latency 1, result_lo=0xFFFFFFFF, result_hi=9, div_by_zero=1.
- Backpressure: hold out_ready=0 for 5 cycles after an SRA a=0x80000000, b=4 -> result_lo stays 0xF8000000, in_ready=0. Then out_ready=1 with a new XOR a=0xF0, b=0xFF -> accepted the same cycle; next result 0x0F.
- Deassert rst_n mid-MULU (cycle 10) -> outputs zero asynchronously. After release, in_ready=1 and no stale out_valid.
